// File: rtl/arbiter_types.sv
// Shared arbiter types: FSM state encoding and requester identity for the
// icache/dcache memory-port arbiter.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Serialises icache line fills and dcache fills/writebacks onto one burst port.
// Optional macro CACHE_ARB_RR_EN: round-robin tie-break instead of dcache priority.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state_reg, state_next;
  arb_req_t   last_grant_reg, last_grant_next;
  arb_req_t   winner;
  logic       i_req, d_req, grant;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // Grant selection
  always_comb begin
    i_req  = i_read;
    d_req  = d_read | d_write;
    winner = REQ_D;
    if (i_req && !d_req) begin
      winner = REQ_I;
    end else if (i_req && d_req) begin
`ifdef CACHE_ARB_RR_EN
      winner = (last_grant_reg == REQ_I) ? REQ_D : REQ_I;
`else
      winner = REQ_D;
`endif
    end
    sel_addr = (winner == REQ_I) ? i_addr : d_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= REQ_I;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          state_next = (winner == REQ_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_next      = IDLE;
          last_grant_next = REQ_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_next      = IDLE;
          last_grant_next = REQ_D;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion is combinational so the owner sees resp in the adaptor's cycle
  assign i_resp  = (state_reg == SERVE_I) && mem_resp;
  assign d_resp  = (state_reg == SERVE_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Captured request; a simultaneous dcache read+write forwards only the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      mem_addr  <= {sel_addr[ADDR_WIDTH-1:5], 5'b0};
      mem_wdata <= d_wdata;
      if (winner == REQ_I) begin
        mem_read  <= 1'b1;
        mem_write <= 1'b0;
      end else begin
        mem_read  <= d_read & ~d_write;
        mem_write <= d_write;
      end
    end else if ((state_reg != IDLE) && mem_resp) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single burst memory port between the instruction cache and the data cache of the mp4 pipeline. It sits between the two caches' line-fill/writeback ports and the cacheline adaptor that drives the physical `mem_*` burst interface. It serialises requests, latches the granted request's address and data, and routes the response back to the owner only.

## Interface
Parameters:
- `LINE_WIDTH`, 256, cache line width in bits.
- `ADDR_WIDTH`, 32, byte address width.

Ports:
- `clk`  in  1  system clock; all flops rise-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  icache line-fill request.
- `i_addr`  in  ADDR_WIDTH  icache line address.
- `i_rdata`  out  LINE_WIDTH  fill data to icache.
- `i_resp`  out  1  icache completion pulse.
- `d_read`  in  1  dcache line-fill request.
- `d_write`  in  1  dcache writeback request.
- `d_addr`  in  ADDR_WIDTH  dcache line address.
- `d_wdata`  in  LINE_WIDTH  dcache writeback line.
- `d_rdata`  out  LINE_WIDTH  fill data to dcache.
- `d_resp`  out  1  dcache completion pulse.
- `mem_read`  out  1  read request to adaptor.
- `mem_write`  out  1  write request to adaptor.
- `mem_addr`  out  ADDR_WIDTH  line-aligned address to adaptor.
- `mem_wdata`  out  LINE_WIDTH  write line to adaptor.
- `mem_rdata`  in  LINE_WIDTH  read line from adaptor.
- `mem_resp`  in  1  adaptor completion.

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`. Reset state is `IDLE`.
- A `last_grant` flop holds the last granted requester. It resets to the icache.
- In `IDLE`:
  - Only the icache requests: go to `SERVE_I`.
  - Only the dcache requests: go to `SERVE_D`.
  - Both request: the winner is set by the configuration below.
- Request capture at the grant edge:
  - `mem_addr` latches `{addr[ADDR_WIDTH-1:5], 5'b0}`. The low 5 bits are always zeroed.
  - `mem_wdata` latches `d_wdata`.
  - `mem_read` / `mem_write` latch the requester's read/write.
  - If `d_read` and `d_write` are both asserted, this is illegal; the write is forwarded.
- In `SERVE_x`:
  - The latched `mem_*` outputs are held constant.
  - Requester inputs are ignored. A request dropped mid-transaction still completes and still pulses resp.
- On `mem_resp` while in `SERVE_x`:
  - `x_resp` = 1 in the same cycle; the other resp stays 0.
  - Transition to `IDLE`, update `last_grant`, clear `mem_read` / `mem_write`.
- `i_rdata` and `d_rdata` are both wired directly to `mem_rdata`. Qualification is by resp only.
- `mem_resp` while in `IDLE` is ignored; no resp is generated.
- Reset asserted mid-transaction: immediately return to `IDLE` and clear all registered outputs. The adaptor must be reset by the same signal.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `i_resp`=0, `d_resp`=0.
- A request sampled in `IDLE` in cycle N gives `mem_read`/`mem_write` high in cycle N+1 (registered outputs).
- `mem_resp` in cycle M gives `x_resp` in cycle M (combinational from state & `mem_resp`). `mem_*` deassert in M+1.
- Requesters deassert their request in M+1. The earliest next grant is sampled in M+1, with a mem request in M+2.
- Arbiter overhead per transaction: 1 cycle before and 1 cycle after the adaptor latency.
- `resp` is a single-cycle pulse per transaction. There is never more than one outstanding transaction.

## Configuration
- `CACHE_ARB_RR_EN`:
  - Defined: when both request in `IDLE`, the requester that is not `last_grant` wins (round-robin).
  - Undefined: the dcache always wins a tie (fixed priority); `last_grant` is still maintained but unused.

## Structure
- `arb_state_t` enum (`IDLE`, `SERVE_I`, `SERVE_D`) and the `arb_req_t` enum (`REQ_I`, `REQ_D`, used for `last_grant`) go in a shared `arbiter_types` package alongside `rv32i_types`.
- Single flat module. No sub-module; the grant selection is one combinational block.

## Test plan
- Icache-only read to `0x0000_0064`, adaptor responds 4 cycles later with line `L`:
  - `mem_read`=1 and `mem_addr`=`0x0000_0060` from cycle N+1.
  - `i_resp`=1 with `i_rdata`=`L` for exactly one cycle; `d_resp` stays 0.
- Dcache writeback of line `W` to `0x0000_1000`:
  - `mem_write`=1 and `mem_wdata`=`W` held stable until `mem_resp`.
  - `d_resp` pulses once.
- Simultaneous `i_read` and `d_read` in three consecutive transactions:
  - With `CACHE_ARB_RR_EN`: grants D, I, D. The first tie resolves to D because `last_grant` resets to I.
  - Without it: D, D, D while dcache keeps requesting.
- `i_read` dropped after grant, before `mem_resp`: the transaction completes, `i_resp` still pulses once, and no spurious `d_resp` occurs.
- Spurious `mem_resp` in `IDLE`: no resp output and no state change.
- Reset asserted in `SERVE_D`: all outputs go to 0 asynchronously, state is `IDLE`, and after release a fresh `i_read` is granted normally.
